wb_cpu_master: RTL and testbench
================================

Name: wb_cpu_master

Overview:
- CPU-side Wishbone initiator for the multi-cycle MIPS core.
- Takes single load/store requests that the CPU issues to the device address window. Decodes the target (timer or UART), drives the STB/WE/ADR/DAT strobes toward the device slaves, and waits for ACK.
- Returns read data and a completion pulse that releases the CPU's memory-stage stall.
- Unmapped addresses and non-responding slaves complete with an error flag instead of hanging the core.

Parameters:
- DEV_BASE, 25'h0000FE: required value of cpu_addr[31:7] for a device access.
- TIMEOUT, 16: cycles to wait for ACK before aborting; must be 2..255.

Ports:
- PClk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- cpu_req  in  1  single-cycle request pulse; sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  8  store data
- cpu_rdata  out  8  load data; valid when cpu_done = 1
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_done: unmapped or timed out
- ADR  out  5  word address to slaves, equal to latched cpu_addr[6:2]
- DAT  out  8  write data to slaves
- WE  out  1  write enable to slaves
- STB_TMR  out  1  timer strobe
- ACK_TMR  in  1  timer acknowledge
- DAT_TMR  in  8  timer read data
- STB_UART  out  1  UART strobe
- ACK_UART  in  1  UART acknowledge
- DAT_UART  in  8  UART read data

Behaviour:
- Reset (synchronous, on PClk while Reset = 1): all outputs 0, state IDLE, internal timeout counter 0. If Reset is asserted mid-transaction, STB drops on the next edge and no cpu_done is issued for that transaction.
- Decode, from cpu_addr in IDLE:
  - hit = (cpu_addr[31:7] == DEV_BASE)
  - sel_tmr = hit & (cpu_addr[6:5] == 2'b01)
  - sel_uart = hit & (cpu_addr[6:5] == 2'b10)
  - anything else is unmapped.
- State IDLE, on cpu_req:
  - Mapped: latch ADR, DAT, WE and the select; next state BUS.
  - Unmapped: next state DONE with err = 1, rdata = 0. No strobe is ever asserted.
  - cpu_req in any other state is ignored.
- State BUS:
  - The selected STB is 1; the other STB is 0. ADR, DAT and WE are held stable.
  - The timeout counter increments each cycle.
  - If the selected ACK = 1: capture the selected DAT_x into cpu_rdata (loads only; stores leave rdata at 0), err = 0, next state DONE.
  - Else, if counter == TIMEOUT-1: err = 1, rdata = 0, next state DONE.
  - ACK has priority over timeout in the same cycle.
  - The ACK of the non-selected slave is ignored.
- State DONE:
  - STB is deasserted. cpu_done = 1 for exactly this one cycle, with cpu_err valid.
  - Next state IDLE; the counter clears.
  - cpu_rdata holds its value until the next completion.
- Latency:
  - Combinational-ACK slave (ACK = STB): req at cycle 0, STB high in cycle 1, done in cycle 2.
  - Slave acking n cycles after STB rises: done at cycle 2+n.
- Strobes: at most one STB is high at any time. STB is never high in IDLE or DONE.
- Back-to-back: a new cpu_req is accepted in IDLE the cycle after DONE. Minimum request spacing is 3 cycles.
- Outputs are registered. There is no combinational path from any ACK to STB.

Test Plan:
- Reset for 2 cycles -> all outputs 0. Then cpu_req with store to 0x00007F24, data 0xA5, ACK_TMR tied to STB_TMR -> cycle 1: STB_TMR = 1, WE = 1, ADR = 5'b01001, DAT = 0xA5. Cycle 2: cpu_done = 1, cpu_err = 0.
- Load from 0x00007F40, UART acks 3 cycles after STB with DAT_UART = 0x3C -> STB_UART high for 4 cycles, then cpu_rdata = 0x3C, cpu_done at cycle 5, STB_TMR stays 0 throughout.
- Load from 0x00007F00 (unmapped window) and from 0x00001F24 (wrong base) -> no STB. cpu_done in cycle 1 with cpu_err = 1, cpu_rdata = 0.
- Timer never acks, TIMEOUT = 16 -> STB_TMR high for exactly 16 cycles, then cpu_done with cpu_err = 1; next request proceeds normally.
- Reset asserted in the 2nd BUS cycle of a UART access -> STB_UART = 0 next cycle, no cpu_done pulse. A spurious late ACK_UART in IDLE is ignored.
- Timer ACK on the same cycle the counter hits TIMEOUT-1 -> cpu_err = 0 and rdata captured. A cpu_req pulsed during BUS is dropped; only one transaction is observed.

Source files
------------

// File: rtl/wb_cpu_master.sv
// CPU-side Wishbone initiator: single load/store to the timer or UART slave,
// with unmapped-address and ACK-timeout completion so the core never hangs.
module wb_cpu_master #(
    parameter logic [24:0] DEV_BASE = 25'h0000FE,
    parameter int          TIMEOUT  = 16
) (
    input  logic        PClk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [4:0]  ADR,
    output logic [7:0]  DAT,
    output logic        WE,
    output logic        STB_TMR,
    input  logic        ACK_TMR,
    input  logic [7:0]  DAT_TMR,
    output logic        STB_UART,
    input  logic        ACK_UART,
    input  logic [7:0]  DAT_UART
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [4:0]  adr_q, adr_d;
    logic [7:0]  dat_q, dat_d;
    logic        we_q, we_d;
    logic        stb_tmr_q, stb_tmr_d;
    logic        stb_uart_q, stb_uart_d;

    logic        hit_s;
    logic        sel_tmr_s;
    logic        sel_uart_s;
    logic        ack_sel_s;
    logic [7:0]  dat_sel_s;
    logic        addr_lsb_unused;

    // Byte lanes below the word address are irrelevant to 8-bit slaves.
    assign addr_lsb_unused = ^cpu_addr[1:0];

    assign cpu_rdata = rdata_q;
    assign cpu_done  = done_q;
    assign cpu_err   = err_q;
    assign ADR       = adr_q;
    assign DAT       = dat_q;
    assign WE        = we_q;
    assign STB_TMR   = stb_tmr_q;
    assign STB_UART  = stb_uart_q;

    // Device window decode of the incoming request address.
    always_comb begin
        hit_s      = (cpu_addr[31:7] == DEV_BASE);
        sel_tmr_s  = hit_s && (cpu_addr[6:5] == 2'b01);
        sel_uart_s = hit_s && (cpu_addr[6:5] == 2'b10);
    end

    // The registered strobe doubles as the latched slave select, so the
    // non-selected slave's ACK and data are never looked at.
    always_comb begin
        if (stb_tmr_q) begin
            ack_sel_s = ACK_TMR;
            dat_sel_s = DAT_TMR;
        end else if (stb_uart_q) begin
            ack_sel_s = ACK_UART;
            dat_sel_s = DAT_UART;
        end else begin
            ack_sel_s = 1'b0;
            dat_sel_s = 8'h00;
        end
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        err_d      = err_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        stb_tmr_d  = stb_tmr_q;
        stb_uart_d = stb_uart_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (cpu_req) begin
                    if (sel_tmr_s || sel_uart_s) begin
                        state_d    = ST_BUS;
                        adr_d      = cpu_addr[6:2];
                        dat_d      = cpu_wdata;
                        we_d       = cpu_we;
                        stb_tmr_d  = sel_tmr_s;
                        stb_uart_d = sel_uart_s;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = 8'h00;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUS: begin
                cnt_d = cnt_q + 8'd1;
                // ACK wins over a timeout landing in the same cycle.
                if (ack_sel_s) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    err_d      = 1'b0;
                    rdata_d    = we_q ? 8'h00 : dat_sel_s;
                    stb_tmr_d  = 1'b0;
                    stb_uart_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    rdata_d    = 8'h00;
                    stb_tmr_d  = 1'b0;
                    stb_uart_d = 1'b0;
                end else begin
                    state_d = ST_BUS;
                end
            end

            ST_DONE: begin
                state_d    = ST_IDLE;
                cnt_d      = 8'd0;
                err_d      = 1'b0;
                stb_tmr_d  = 1'b0;
                stb_uart_d = 1'b0;
            end

            default: begin
                state_d    = ST_IDLE;
                cnt_d      = 8'd0;
                err_d      = 1'b0;
                stb_tmr_d  = 1'b0;
                stb_uart_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge PClk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            rdata_q    <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            adr_q      <= 5'd0;
            dat_q      <= 8'h00;
            we_q       <= 1'b0;
            stb_tmr_q  <= 1'b0;
            stb_uart_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            stb_tmr_q  <= stb_tmr_d;
            stb_uart_q <= stb_uart_d;
        end
    end

endmodule

// File: tb/tb_wb_cpu_master.sv
// Scoreboard bench for wb_cpu_master: stimulus pushes expected completions,
// a negedge monitor checks bus strobes and completions against them.
module tb_wb_cpu_master;

    localparam int          TIMEOUT  = 16;
    localparam logic [24:0] DEV_BASE = 25'h0000FE;

    logic        PClk = 1'b0;
    logic        Reset = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic [7:0]  cpu_rdata;
    logic        cpu_done, cpu_err;
    logic [4:0]  ADR;
    logic [7:0]  DAT;
    logic        WE, STB_TMR, STB_UART;
    logic        ACK_TMR, ACK_UART;
    logic [7:0]  DAT_TMR = 8'h0;
    logic [7:0]  DAT_UART = 8'h0;

    int   tmr_delay = 0, uart_delay = 0, tmr_cnt = 0, uart_cnt = 0;
    logic tmr_spur = 1'b0, uart_spur = 1'b0;

    wb_cpu_master #(.DEV_BASE(DEV_BASE), .TIMEOUT(TIMEOUT)) dut (
        .PClk(PClk), .Reset(Reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_done(cpu_done), .cpu_err(cpu_err), .ADR(ADR), .DAT(DAT), .WE(WE),
        .STB_TMR(STB_TMR), .ACK_TMR(ACK_TMR), .DAT_TMR(DAT_TMR),
        .STB_UART(STB_UART), .ACK_UART(ACK_UART), .DAT_UART(DAT_UART)
    );

    always #5 PClk = ~PClk;

    // Slave models: ack after a programmable number of strobe cycles.
    always @(posedge PClk) begin
        tmr_cnt  <= STB_TMR  ? tmr_cnt + 1  : 0;
        uart_cnt <= STB_UART ? uart_cnt + 1 : 0;
    end
    assign ACK_TMR  = (STB_TMR  && (tmr_cnt  == tmr_delay))  || tmr_spur;
    assign ACK_UART = (STB_UART && (uart_cnt == uart_delay)) || uart_spur;

    typedef struct {
        int         req_cyc;
        int         lat;
        logic       err;
        logic [7:0] rdata;
        int         target;
        logic [4:0] adr;
        logic [7:0] dat;
        logic       we;
        int         stb_len;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, stb_cnt = 0;

    always @(posedge PClk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: outcome of one request from the address map and slave behaviour.
    function automatic exp_t model(input logic [31:0] addr, input logic we, input logic [7:0] wdata,
                                   input int tdel, input int udel, input int req_cyc);
        exp_t e;
        int   n;
        e.req_cyc = req_cyc;
        e.we      = we;
        e.dat     = wdata;
        e.adr     = 5'((addr >> 2) & 32'd31);
        if ((addr >> 7) != {7'd0, DEV_BASE}) e.target = 0;
        else if (((addr >> 5) & 32'd3) == 32'd1) e.target = 1;
        else if (((addr >> 5) & 32'd3) == 32'd2) e.target = 2;
        else e.target = 0;
        if (e.target == 0) begin
            e.lat = 1; e.err = 1'b1; e.rdata = 8'h00; e.stb_len = 0;
        end else begin
            n = (e.target == 1) ? tdel : udel;
            if (n < TIMEOUT) begin
                e.lat = 2 + n; e.err = 1'b0; e.stb_len = n + 1;
                e.rdata = we ? 8'h00 : ((e.target == 1) ? DAT_TMR : DAT_UART);
            end else begin
                e.lat = 1 + TIMEOUT; e.err = 1'b1; e.rdata = 8'h00; e.stb_len = TIMEOUT;
            end
        end
        return e;
    endfunction

    // Monitor: strobe legality every cycle, completion compare on cpu_done.
    always @(negedge PClk) begin
        if (Reset) begin
            stb_cnt = 0;
            chk("reset_outputs", {6'd0, cpu_rdata, cpu_done, cpu_err, ADR, DAT, WE, STB_TMR, STB_UART}, 32'd0);
        end else begin
            chk("one_hot_stb", {31'd0, STB_TMR & STB_UART}, 32'd0);
            if (STB_TMR || STB_UART) begin
                stb_cnt++;
                if (sb.size() == 0) chk("stray_stb", 32'd1, 32'd0);
                else begin
                    chk("stb_target", {30'd0, STB_UART, STB_TMR}, sb[0].target);
                    chk("bus_adr", {27'd0, ADR}, {27'd0, sb[0].adr});
                    chk("bus_dat", {24'd0, DAT}, {24'd0, sb[0].dat});
                    chk("bus_we", {31'd0, WE}, {31'd0, sb[0].we});
                end
            end
            if (cpu_done) begin
                if (sb.size() == 0) chk("stray_done", 32'd1, 32'd0);
                else begin
                    mon_e = sb.pop_front();
                    chk("latency", cyc - mon_e.req_cyc, mon_e.lat);
                    chk("err", {31'd0, cpu_err}, {31'd0, mon_e.err});
                    chk("rdata", {24'd0, cpu_rdata}, {24'd0, mon_e.rdata});
                    chk("stb_len", stb_cnt, mon_e.stb_len);
                end
                stb_cnt = 0;
                done_cnt++;
            end
        end
    end

    // One request, waits (bounded) for completion and returns in an IDLE cycle.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [7:0] wdata,
                         input int tdel, input int udel, input logic spur, input logic extra_req);
        exp_t e;
        int   d0;
        tmr_delay  = tdel;
        uart_delay = udel;
        e = model(addr, we, wdata, tdel, udel, cyc);
        if (e.target == 1) uart_spur = spur;
        if (e.target == 2) tmr_spur = spur;
        sb.push_back(e);
        d0 = done_cnt;
        cpu_addr = addr; cpu_we = we; cpu_wdata = wdata; cpu_req = 1'b1;
        @(negedge PClk); #1;
        cpu_req = 1'b0;
        if (extra_req) begin
            cpu_addr = {DEV_BASE, 7'h44}; cpu_req = 1'b1;
            @(negedge PClk); #1;
            cpu_req = 1'b0;
        end
        for (int i = 0; i < 100 && done_cnt == d0; i++) begin
            @(negedge PClk); #1;
        end
        if (done_cnt == d0) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        tmr_spur = 1'b0; uart_spur = 1'b0;
        @(negedge PClk); #1;
    endtask

    initial begin
        int d0;
        logic [31:0] a;
        repeat (2) @(negedge PClk);
        #1 Reset = 1'b0;
        @(negedge PClk); #1;

        issue(32'h00007F24, 1'b1, 8'hA5, 0, 0, 1'b0, 1'b0);
        DAT_UART = 8'h3C; DAT_TMR = 8'h99;
        issue(32'h00007F40, 1'b0, 8'h00, 0, 3, 1'b0, 1'b0);
        issue(32'h00007F00, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);
        issue(32'h00001F24, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0);
        issue(32'h00007F24, 1'b0, 8'h00, 200, 0, 1'b0, 1'b0);
        DAT_TMR = 8'h5A;
        issue(32'h00007F28, 1'b0, 8'h00, 1, 0, 1'b0, 1'b0);

        // Reset during the second BUS cycle of a UART load.
        uart_delay = 200;
        sb.push_back(model(32'h00007F44, 1'b0, 8'h00, 0, 200, cyc));
        d0 = done_cnt;
        cpu_addr = 32'h00007F44; cpu_we = 1'b0; cpu_req = 1'b1;
        @(negedge PClk); #1 cpu_req = 1'b0;
        @(negedge PClk); #1 Reset = 1'b1;
        sb.delete();
        @(negedge PClk); #1 Reset = 1'b0;
        uart_spur = 1'b1;
        repeat (3) @(negedge PClk);
        #1 uart_spur = 1'b0;
        chk("no_done_after_reset", done_cnt, d0);

        DAT_TMR = 8'hC3;
        issue(32'h00007F3C, 1'b0, 8'h00, TIMEOUT - 1, 0, 1'b0, 1'b1);
        issue(32'h00007F30, 1'b0, 8'h00, TIMEOUT, 0, 1'b0, 1'b0);
        issue(32'h00007F50, 1'b1, 8'h17, 0, 2, 1'b1, 1'b0);

        for (int k = 0; k < 60; k++) begin
            a = ($urandom_range(0, 4) == 0) ? $urandom : {DEV_BASE, 7'($urandom)};
            DAT_TMR  = 8'($urandom);
            DAT_UART = 8'($urandom);
            issue(a, 1'($urandom), 8'($urandom), $urandom_range(0, 20), $urandom_range(0, 20),
                  1'($urandom), 1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge PClk);
            #1;
        end

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
